io_int_arbiter: RTL and testbench

- Interrupt arbiter between the LC-3 memory-mapped I/O devices (keyboard, display, timer, spare) and the CPU interrupt-entry sequence.
- Samples each device's status Ready bit (bit 15) and IE bit (bit 14), and selects the highest-priority request strictly above the CPU's current PSR priority.
- Presents that request to the CPU with a req/ack handshake, then returns the vector and a one-hot grant.
- Sits beside the memory-mapped I/O decode. Keyboard is device 0.

---
 rtl/io_int_arbiter_if.sv | 28 ++
 rtl/io_int_arbiter.sv | 177 +++++++++++++++++
 tb/tb_io_int_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/io_int_arbiter_if.sv
// Purpose : handshake/bus bundle between LC-3 I/O devices, the CPU and io_int_arbiter.
// Ports   : dev_ready/dev_ie/dev_pri/dev_vec per slot, cpu_pl and int_ack from the CPU,
//           int_req/int_vec/int_pri/int_grant back to the CPU. slave = arbiter view.
interface io_int_arbiter_if #(
  parameter int N_DEV = 4,
  parameter int VEC_W = 8
);
  logic [N_DEV-1:0]       dev_ready;
  logic [N_DEV-1:0]       dev_ie;
  logic [3*N_DEV-1:0]     dev_pri;
  logic [VEC_W*N_DEV-1:0] dev_vec;
  logic [2:0]             cpu_pl;
  logic                   int_ack;
  logic                   int_req;
  logic [VEC_W-1:0]       int_vec;
  logic [2:0]             int_pri;
  logic [N_DEV-1:0]       int_grant;

  modport master (
    output dev_ready, dev_ie, dev_pri, dev_vec, cpu_pl, int_ack,
    input  int_req, int_vec, int_pri, int_grant
  );

  modport slave (
    input  dev_ready, dev_ie, dev_pri, dev_vec, cpu_pl, int_ack,
    output int_req, int_vec, int_pri, int_grant
  );
endinterface

// File: rtl/io_int_arbiter.sv
// Purpose : LC-3 interrupt arbiter; picks the highest-priority ready+enabled device above cpu_pl.
// Latency : candidate before edge N -> int_req high after edge N+1; int_grant one cycle after ack.
// Backpressure: int_req held with stable vec/pri until int_ack or withdrawal; HOLD blocks re-request.
// Ports   : clk, rst_n (async active-low), bus (io_int_arbiter_if.slave).
// Option  : define INT_ROUND_ROBIN_EN for rotating-pointer tie-break (default: lowest index wins).
module io_int_arbiter #(
  parameter int N_DEV = 4,
  parameter int VEC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  io_int_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_DEV);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_REQ   = 3'd2,
    ST_GRANT = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             int_req_q, int_req_d;
  logic [VEC_W-1:0] int_vec_q, int_vec_d;
  logic [2:0]       int_pri_q, int_pri_d;
  logic [N_DEV-1:0] int_grant_q, int_grant_d;
  logic [IW-1:0]    win_idx_q, win_idx_d;
`ifdef INT_ROUND_ROBIN_EN
  logic [IW-1:0]    ptr_q, ptr_d;
`endif

  logic [N_DEV-1:0] cand;
  logic             any_cand;
  logic             nest;
  logic [N_DEV-1:0] win_onehot;
  logic [IW-1:0]    best_idx;
  logic [2:0]       best_pri;
  logic [VEC_W-1:0] best_vec;

  // Candidate mask; priority 0 can never exceed cpu_pl so it never interrupts.
  always_comb begin
    cand = '0;
    for (int i = 0; i < N_DEV; i++) begin
      cand[i] = bus.dev_ready[i] & bus.dev_ie[i] & (bus.dev_pri[3*i +: 3] > bus.cpu_pl);
    end
  end

  assign any_cand = |cand;

  // Winner search. Every candidate has priority >= 1, so starting best_pri at 0
  // with a strict compare lets the first candidate in search order win ties.
  always_comb begin
    int j;
    j        = 0;
    best_idx = '0;
    best_pri = '0;
    for (int k = 0; k < N_DEV; k++) begin
`ifdef INT_ROUND_ROBIN_EN
      j = int'(ptr_q) + k;
      if (j >= N_DEV) j = j - N_DEV;
`else
      j = k;
`endif
      if (cand[j] && (bus.dev_pri[3*j +: 3] > best_pri)) begin
        best_idx = IW'(j);
        best_pri = bus.dev_pri[3*j +: 3];
      end
    end
  end

  assign best_vec = bus.dev_vec[VEC_W*int'(best_idx) +: VEC_W];

  // Nesting out of HOLD: another slot above the granted priority.
  always_comb begin
    nest       = 1'b0;
    win_onehot = '0;
    for (int i = 0; i < N_DEV; i++) begin
      win_onehot[i] = (win_idx_q == IW'(i));
      if (cand[i] && (i != int'(win_idx_q)) && (bus.dev_pri[3*i +: 3] > int_pri_q)) begin
        nest = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    int_req_d   = int_req_q;
    int_vec_d   = int_vec_q;
    int_pri_d   = int_pri_q;
    int_grant_d = '0;
    win_idx_d   = win_idx_q;
`ifdef INT_ROUND_ROBIN_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_cand) begin
          state_d   = ST_SCAN;
          win_idx_d = best_idx;
          int_vec_d = best_vec;
          int_pri_d = best_pri;
        end
      end
      ST_SCAN: begin
        if (any_cand) begin
          state_d   = ST_REQ;
          int_req_d = 1'b1;
          win_idx_d = best_idx;
          int_vec_d = best_vec;
          int_pri_d = best_pri;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        // Ack beats a same-cycle withdrawal; winner is frozen (no preemption).
        if (bus.int_ack) begin
          state_d     = ST_GRANT;
          int_req_d   = 1'b0;
          int_grant_d = win_onehot;
`ifdef INT_ROUND_ROBIN_EN
          ptr_d = (win_idx_q == IW'(N_DEV-1)) ? '0 : win_idx_q + IW'(1);
`endif
        end else if (!cand[win_idx_q]) begin
          state_d   = ST_IDLE;
          int_req_d = 1'b0;
        end
      end
      ST_GRANT: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // int_pri still holds the granted priority here.
        if (!bus.dev_ready[win_idx_q] || (bus.cpu_pl >= int_pri_q)) begin
          state_d = ST_IDLE;
        end else if (nest) begin
          state_d = ST_SCAN;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        int_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      int_req_q   <= 1'b0;
      int_vec_q   <= '0;
      int_pri_q   <= '0;
      int_grant_q <= '0;
      win_idx_q   <= '0;
`ifdef INT_ROUND_ROBIN_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      int_req_q   <= int_req_d;
      int_vec_q   <= int_vec_d;
      int_pri_q   <= int_pri_d;
      int_grant_q <= int_grant_d;
      win_idx_q   <= win_idx_d;
`ifdef INT_ROUND_ROBIN_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign bus.int_req   = int_req_q;
  assign bus.int_vec   = int_vec_q;
  assign bus.int_pri   = int_pri_q;
  assign bus.int_grant = int_grant_q;
endmodule

// File: tb/tb_io_int_arbiter.sv
// Purpose : directed self-checking bench for io_int_arbiter.
// Latency : inputs driven and outputs sampled on the falling edge.
// Backpressure: the bench plays the CPU, pulsing int_ack and moving cpu_pl.
module tb_io_int_arbiter;
  localparam int N = 4;
  localparam int V = 8;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   dev_ready;
  logic [N-1:0]   dev_ie;
  logic [3*N-1:0] dev_pri;
  logic [V*N-1:0] dev_vec;
  logic [2:0]     cpu_pl;
  logic           int_ack;

  int n_tests = 0;
  int n_fail  = 0;

  io_int_arbiter_if #(.N_DEV(N), .VEC_W(V)) bus ();

  assign bus.dev_ready = dev_ready;
  assign bus.dev_ie    = dev_ie;
  assign bus.dev_pri   = dev_pri;
  assign bus.dev_vec   = dev_vec;
  assign bus.cpu_pl    = cpu_pl;
  assign bus.int_ack   = int_ack;

  io_int_arbiter #(.N_DEV(N), .VEC_W(V)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_dev(input int i, input logic rdy, input logic [2:0] p, input logic [7:0] v);
    dev_ready[i]       = rdy;
    dev_ie[i]          = rdy;
    dev_pri[3*i +: 3]  = p;
    dev_vec[V*i +: V]  = v;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    dev_ready = '0;
    dev_ie    = '0;
    dev_pri   = '0;
    dev_vec   = '0;
    cpu_pl    = 3'd0;
    int_ack   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] exp_g;
    logic [7:0] exp_v;

    // Reset state
    do_reset();
    chk("rst_req",   32'(bus.int_req),   32'h0);
    chk("rst_vec",   32'(bus.int_vec),   32'h0);
    chk("rst_pri",   32'(bus.int_pri),   32'h0);
    chk("rst_grant", 32'(bus.int_grant), 32'h0);

    // Keyboard only: two-cycle latency, ack -> one-cycle grant, then HOLD
    set_dev(0, 1'b1, 3'd4, 8'h80);
    step();
    chk("kb_req_c1", 32'(bus.int_req), 32'h0);
    step();
    chk("kb_req_c2", 32'(bus.int_req), 32'h1);
    chk("kb_vec",    32'(bus.int_vec), 32'h80);
    chk("kb_pri",    32'(bus.int_pri), 32'h4);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("kb_ack_req", 32'(bus.int_req),   32'h0);
    chk("kb_grant",   32'(bus.int_grant), 32'h1);
    step();
    chk("kb_grant_clr", 32'(bus.int_grant), 32'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("hold_no_req", 32'(bus.int_req), 32'h0);
    end
    // Nesting: a higher-priority slot escapes HOLD
    set_dev(2, 1'b1, 3'd6, 8'h82);
    step();
    step();
    chk("nest_req", 32'(bus.int_req), 32'h1);
    chk("nest_vec", 32'(bus.int_vec), 32'h82);

    // HOLD release by dropping ready of the granted slot
    do_reset();
    set_dev(0, 1'b1, 3'd4, 8'h80);
    step(); step();
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    step(); step(); step();
    chk("hold2_no_req", 32'(bus.int_req), 32'h0);
    dev_ready[0] = 1'b0;
    step();
    dev_ready[0] = 1'b1;
    step(); step();
    chk("hold_rel_req", 32'(bus.int_req), 32'h1);

    // Priority masking
    do_reset();
    set_dev(0, 1'b1, 3'd4, 8'h80);
    cpu_pl = 3'd4;
    step(); step(); step(); step();
    chk("mask_req", 32'(bus.int_req), 32'h0);
    cpu_pl = 3'd3;
    step();
    chk("unmask_c1", 32'(bus.int_req), 32'h0);
    step();
    chk("unmask_c2", 32'(bus.int_req), 32'h1);

    // Arbitration by priority
    do_reset();
    set_dev(0, 1'b1, 3'd4, 8'h80);
    set_dev(2, 1'b1, 3'd6, 8'h82);
    step(); step();
    chk("arb_req", 32'(bus.int_req), 32'h1);
    chk("arb_vec", 32'(bus.int_vec), 32'h82);
    chk("arb_pri", 32'(bus.int_pri), 32'h6);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("arb_grant", 32'(bus.int_grant), 32'h4);

    // Withdrawal before ack
    do_reset();
    set_dev(0, 1'b1, 3'd4, 8'h80);
    step(); step();
    chk("wd_req", 32'(bus.int_req), 32'h1);
    dev_ready[0] = 1'b0;
    step();
    chk("wd_req_drop", 32'(bus.int_req),   32'h0);
    chk("wd_no_grant", 32'(bus.int_grant), 32'h0);
    dev_ready[0] = 1'b1;
    step();
    chk("wd_idle_c1", 32'(bus.int_req), 32'h0);
    step();
    chk("wd_idle_c2", 32'(bus.int_req), 32'h1);
    // Ack and withdrawal together: ack wins
    int_ack      = 1'b1;
    dev_ready[0] = 1'b0;
    step();
    int_ack = 1'b0;
    chk("wd_ack_grant", 32'(bus.int_grant), 32'h1);
    chk("wd_ack_req",   32'(bus.int_req),   32'h0);

    // Reset while in REQ
    do_reset();
    set_dev(0, 1'b1, 3'd4, 8'h80);
    step(); step();
    chk("mr_req", 32'(bus.int_req), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mr_req0", 32'(bus.int_req),   32'h0);
    chk("mr_vec0", 32'(bus.int_vec),   32'h0);
    chk("mr_pri0", 32'(bus.int_pri),   32'h0);
    chk("mr_gnt0", 32'(bus.int_grant), 32'h0);
    step(); step();
    chk("mr_in_rst", 32'(bus.int_req), 32'h0);
    rst_n = 1'b1;
    step();
    chk("mr_rel_c1", 32'(bus.int_req), 32'h0);
    step();
    chk("mr_rel_c2", 32'(bus.int_req), 32'h1);

    // Equal-priority tie-break over three service rounds
    do_reset();
    set_dev(0, 1'b1, 3'd4, 8'h80);
    set_dev(1, 1'b1, 3'd4, 8'h81);
    for (int r = 0; r < 3; r++) begin
`ifdef INT_ROUND_ROBIN_EN
      exp_g = (r % 2 == 0) ? 4'b0001 : 4'b0010;
      exp_v = (r % 2 == 0) ? 8'h80 : 8'h81;
`else
      exp_g = 4'b0001;
      exp_v = 8'h80;
`endif
      step(); step();
      chk("tie_req", 32'(bus.int_req), 32'h1);
      chk("tie_vec", 32'(bus.int_vec), 32'(exp_v));
      int_ack = 1'b1;
      step();
      int_ack = 1'b0;
      chk("tie_grant", 32'(bus.int_grant), 32'(exp_g));
      // ISR raises the level, then returns
      cpu_pl = 3'd4;
      step(); step();
      cpu_pl = 3'd0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
